// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types, constants and parameter checks for the
//               falling-edge pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

  // Pulse sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } edge_state_e;

  // Width of the high/gap down-counter
  localparam int CNT_W = 8;

  // Legal range for HIGH_CYCLES and GAP_CYCLES
  function automatic bit cycles_in_range(input int v);
    return (v >= 1) && (v <= 255);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : edge_pulse_gen
// Description : Drives selected lines high for HIGH_CYCLES clocks, then low,
//               producing one clean 1->0 edge per selected bit, followed by a
//               GAP_CYCLES low interval. One request may wait in a pending
//               slot while a pulse is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse_gen
  import edge_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int HIGH_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_mask,
  output logic             req_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [WIDTH-1:0] edge_done,
  output logic [15:0]      pulse_count
);

  // Reject out-of-range cycle counts at elaboration
  if (!cycles_in_range(HIGH_CYCLES)) begin : g_bad_high_cycles
    $error("edge_pulse_gen: HIGH_CYCLES must be within 1..255");
  end
  if (!cycles_in_range(GAP_CYCLES)) begin : g_bad_gap_cycles
    $error("edge_pulse_gen: GAP_CYCLES must be within 1..255");
  end

  localparam logic [CNT_W-1:0] C_HIGH_RELOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);

  edge_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] edge_done_q;
  logic [15:0]      pulse_count_q;
  logic             busy_q;

  logic             w_pending_vld;
  logic             w_accept;
  logic             w_req_nonzero;

  // The pending slot is "full" whenever it holds a nonzero mask
  assign w_pending_vld = |pending_q;
  assign req_ready     = ~w_pending_vld;
  assign w_accept      = req_valid & req_ready;
  assign w_req_nonzero = |req_mask;

  // Pulse sequencer: state, counter, pending slot and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      out_q         <= '0;
      edge_done_q   <= '0;
      pulse_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      edge_done_q <= '0;

      case (state_q)
        IDLE: begin
          if (w_pending_vld) begin
            active_q  <= pending_q;
            out_q     <= pending_q;
            pending_q <= '0;
            cnt_q     <= C_HIGH_RELOAD;
            state_q   <= HIGH;
            busy_q    <= 1'b1;
          end else if (w_accept && w_req_nonzero) begin
            // Bypass: lines rise on the same edge that accepts the request
            active_q <= req_mask;
            out_q    <= req_mask;
            cnt_q    <= C_HIGH_RELOAD;
            state_q  <= HIGH;
            busy_q   <= 1'b1;
          end
        end

        HIGH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            out_q         <= '0;
            edge_done_q   <= active_q;
            pulse_count_q <= pulse_count_q + 16'd1;
            cnt_q         <= C_GAP_RELOAD;
            state_q       <= GAP;
          end
        end

        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (w_pending_vld) begin
            // Chain straight into the next pulse so the low time is exact
            active_q  <= pending_q;
            out_q     <= pending_q;
            pending_q <= '0;
            cnt_q     <= C_HIGH_RELOAD;
            state_q   <= HIGH;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          out_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      // Requests arriving mid-pulse park in the slot; loads above only
      // happen when the slot is full, so they never collide with this write
      if (w_accept && w_req_nonzero && (state_q != IDLE)) begin
        pending_q <= req_mask;
      end
    end
  end

  assign out         = out_q;
  assign busy        = busy_q;
  assign edge_done   = edge_done_q;
  assign pulse_count = pulse_count_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_pulse_gen
// Description : Self-checking bench for edge_pulse_gen (WIDTH=32,
//               HIGH_CYCLES=2, GAP_CYCLES=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_pulse_gen;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic [WIDTH-1:0] req_mask;
  logic             req_ready;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic [WIDTH-1:0] edge_done;
  logic [15:0]      pulse_count;

  int tests;
  int fails;

  edge_pulse_gen #(
    .WIDTH      (WIDTH),
    .HIGH_CYCLES(2),
    .GAP_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_mask   (req_mask),
    .req_ready  (req_ready),
    .out        (out),
    .busy       (busy),
    .edge_done  (edge_done),
    .pulse_count(pulse_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] e_out;
    logic             e_busy;
    logic             e_ready;
    logic [WIDTH-1:0] e_edge;
    logic [15:0]      e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Falling-edge capture model fed from the DUT lines
  logic             mon_en;
  logic [WIDTH-1:0] prev_out;
  logic [WIDTH-1:0] sticky;
  logic [WIDTH-1:0] done_or;

  always @(negedge clk) begin
    if (mon_en) begin
      sticky   = sticky | (prev_out & ~out);
      done_or  = done_or | edge_done;
      prev_out = out;
    end
  end

  initial begin
    logic [WIDTH-1:0] acc_or;
    logic [WIDTH-1:0] m;
    int               n_acc;

    tests     = 0;
    fails     = 0;
    mon_en    = 1'b0;
    prev_out  = '0;
    sticky    = '0;
    done_or   = '0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_mask  = '0;

    // valid, mask, out, busy, ready, edge_done, pulse_count (after the edge)
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 32'h0, 16'd0}); // idle
    // single request 0x2
    vq.push_back('{1'b1, 32'h2,    32'h2, 1'b1, 1'b1, 32'h0, 16'd0});
    vq.push_back('{1'b0, 32'h0,    32'h2, 1'b1, 1'b1, 32'h0, 16'd0});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b1, 1'b1, 32'h2, 16'd1});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 32'h0, 16'd1});
    // back-to-back 0x1 then 0xE
    vq.push_back('{1'b1, 32'h1,    32'h1, 1'b1, 1'b1, 32'h0, 16'd1});
    vq.push_back('{1'b1, 32'hE,    32'h1, 1'b1, 1'b0, 32'h0, 16'd1});
    vq.push_back('{1'b1, 32'hF0,   32'h0, 1'b1, 1'b0, 32'h1, 16'd2}); // not accepted
    vq.push_back('{1'b0, 32'h0,    32'hE, 1'b1, 1'b1, 32'h0, 16'd2});
    vq.push_back('{1'b0, 32'h0,    32'hE, 1'b1, 1'b1, 32'h0, 16'd2});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b1, 1'b1, 32'hE, 16'd3});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 32'h0, 16'd3});
    // zero mask consumed; mask change without valid ignored
    vq.push_back('{1'b1, 32'h0,    32'h0, 1'b0, 1'b1, 32'h0, 16'd3});
    vq.push_back('{1'b0, 32'hFFFF, 32'h0, 1'b0, 1'b1, 32'h0, 16'd3});
    // request accepted on the GAP->IDLE edge is parked, then issued from IDLE
    vq.push_back('{1'b1, 32'h4,    32'h4, 1'b1, 1'b1, 32'h0, 16'd3});
    vq.push_back('{1'b0, 32'h0,    32'h4, 1'b1, 1'b1, 32'h0, 16'd3});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b1, 1'b1, 32'h4, 16'd4});
    vq.push_back('{1'b1, 32'h8,    32'h0, 1'b0, 1'b0, 32'h0, 16'd4});
    vq.push_back('{1'b0, 32'h0,    32'h8, 1'b1, 1'b1, 32'h0, 16'd4});
    vq.push_back('{1'b0, 32'h0,    32'h8, 1'b1, 1'b1, 32'h0, 16'd4});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b1, 1'b1, 32'h8, 16'd5});
    vq.push_back('{1'b0, 32'h0,    32'h0, 1'b0, 1'b1, 32'h0, 16'd5});

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst out",   out,         32'h0);
    check("rst busy",  {31'b0, busy},      32'h0);
    check("rst ready", {31'b0, req_ready}, 32'h1);
    check("rst edge",  edge_done,   32'h0);
    check("rst count", {16'b0, pulse_count}, 32'h0);

    // table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      req_valid = vq[i].valid;
      req_mask  = vq[i].mask;
      @(negedge clk);
      check($sformatf("v%0d out", i),   out,                    vq[i].e_out);
      check($sformatf("v%0d busy", i),  {31'b0, busy},          {31'b0, vq[i].e_busy});
      check($sformatf("v%0d ready", i), {31'b0, req_ready},     {31'b0, vq[i].e_ready});
      check($sformatf("v%0d edge", i),  edge_done,              vq[i].e_edge);
      check($sformatf("v%0d count", i), {16'b0, pulse_count},   {16'b0, vq[i].e_cnt});
    end

    // reset asserted mid-pulse with a request parked
    req_valid = 1'b1;
    req_mask  = 32'h10;
    @(negedge clk);
    check("mid out before rst", out, 32'h10);
    req_mask = 32'h40;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid rst out",   out,                  32'h0);
    check("mid rst busy",  {31'b0, busy},        32'h0);
    check("mid rst ready", {31'b0, req_ready},   32'h1);
    check("mid rst count", {16'b0, pulse_count}, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    req_mask  = '0;
    @(negedge clk);
    check("post rst idle out", out, 32'h0);
    req_valid = 1'b1;
    req_mask  = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check("post rst hi0", out, 32'h20);
    @(negedge clk);
    check("post rst hi1", out, 32'h20);
    @(negedge clk);
    check("post rst low",   out,                  32'h0);
    check("post rst edge",  edge_done,            32'h20);
    check("post rst count", {16'b0, pulse_count}, 32'h1);
    @(negedge clk);
    check("post rst busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("post rst no stale pending", out, 32'h0);

    // randomized loopback through the falling-edge capture model
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    prev_out = '0;
    sticky   = '0;
    done_or  = '0;
    acc_or   = '0;
    n_acc    = 0;
    mon_en   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      m = $urandom;
      if (m == '0) m = 32'h1;
      req_valid = 1'($urandom_range(0, 1));
      req_mask  = m;
      if (req_valid && req_ready) begin
        acc_or = acc_or | m;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    check("loop sticky vs edge_done", sticky, done_or);
    check("loop sticky vs accepted",  sticky, acc_or);
    check("loop pulse count", {16'b0, pulse_count}, {16'b0, 16'(n_acc)});
    check("loop idle busy",   {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
